// File: rtl/noise_arbiter.sv
// noise_arbiter: round-robin arbiter sharing one LFSR noise source among NUM_REQ requesters.
// Optional NOISE_ARB_PRIO0_EN gives requester 0 fixed priority over the round-robin group.
module noise_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WORD_W = 8,
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED = 16'hFFFF
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic [NUM_REQ-1:0]         req_in,
  output logic [NUM_REQ-1:0]         ack_out,
  output logic                       valid_out,
  output logic [WORD_W-1:0]          word_out,
  output logic [$clog2(NUM_REQ)-1:0] word_id_out,
  input  logic                       seed_valid_in,
  input  logic [LFSR_W-1:0]          seed_in,
  output logic                       busy_out
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(WORD_W + 1);
  typedef enum logic [1:0] {IDLE, FILL, DELIVER} state_t;
  state_t r_state, w_state_nxt;
  logic [LFSR_W-1:0] r_lfsr, w_lfsr_step;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_rr_ptr, r_gidx, r_word_id, w_pick;
  logic [IW:0] w_idx;
  logic [WORD_W-1:0] r_word;
  logic [NUM_REQ-1:0] w_req;
  logic w_found, w_grant, w_last;
  assign w_lfsr_step = {r_lfsr[LFSR_W-2:0],
                        r_lfsr[LFSR_W-1] ^ r_lfsr[LFSR_W-3] ^ r_lfsr[LFSR_W-4] ^ r_lfsr[LFSR_W-6]};
  assign w_grant = r_state == IDLE && !seed_valid_in && w_found;
  assign w_last = r_state == FILL && r_cnt == CW'(WORD_W - 1);
  assign word_out = r_word;
  assign word_id_out = r_word_id;
  // First set request at or above rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    w_pick = '0;
    w_found = 1'b0;
    w_idx = '0;
`ifdef NOISE_ARB_PRIO0_EN
    w_req = {req_in[NUM_REQ-1:1], 1'b0};
`else
    w_req = req_in;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (IW+1)'(k);
      w_idx = (w_idx >= (IW+1)'(NUM_REQ)) ? w_idx - (IW+1)'(NUM_REQ) : w_idx;
      if (!w_found && w_req[w_idx[IW-1:0]]) begin
        w_found = 1'b1;
        w_pick = w_idx[IW-1:0];
      end
    end
`ifdef NOISE_ARB_PRIO0_EN
    if (req_in[0]) begin
      w_found = 1'b1;
      w_pick = '0;
    end
`endif
  end
  always_comb begin
    w_state_nxt = r_state;
    valid_out = r_state == DELIVER;
    busy_out = r_state != IDLE;
    ack_out = valid_out ? NUM_REQ'(1) << r_gidx : '0;
    if (w_grant) w_state_nxt = FILL;
    else if (w_last) w_state_nxt = DELIVER;
    else if (r_state == DELIVER) w_state_nxt = IDLE;
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= IDLE;
      r_lfsr <= SEED;
      r_cnt <= '0;
      r_rr_ptr <= '0;
      r_gidx <= '0;
      r_word <= '0;
      r_word_id <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && seed_valid_in) r_lfsr <= (seed_in == '0) ? SEED : seed_in;
      else if (r_state == FILL) r_lfsr <= w_lfsr_step;
      r_cnt <= (r_state == FILL) ? r_cnt + 1'b1 : '0;
      if (w_grant) r_gidx <= w_pick;
      // Capture the word on the final step so it is stable throughout DELIVER and after
      if (w_last) begin
        r_word <= w_lfsr_step[WORD_W-1:0];
        r_word_id <= r_gidx;
      end
`ifdef NOISE_ARB_PRIO0_EN
      if (r_state == DELIVER && r_gidx != '0)
`else
      if (r_state == DELIVER)
`endif
        r_rr_ptr <= (r_gidx == IW'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;
    end
  end
endmodule

// File: tb/tb_noise_arbiter.sv
// tb_noise_arbiter: randomized scoreboard bench for noise_arbiter with a transaction-level model.
module tb_noise_arbiter;
  localparam int N = 4;
  localparam int W = 8;
`ifdef NOISE_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif
  logic clk_in, rst_n_in, valid_out, busy_out, seed_valid_in;
  logic [N-1:0] req_in, ack_out;
  logic [W-1:0] word_out;
  logic [1:0] word_id_out;
  logic [15:0] seed_in;
  noise_arbiter dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .req_in(req_in), .ack_out(ack_out),
    .valid_out(valid_out), .word_out(word_out), .word_id_out(word_id_out),
    .seed_valid_in(seed_valid_in), .seed_in(seed_in), .busy_out(busy_out)
  );
  typedef struct {int id; logic [7:0] word; int at;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0, cyc = 0, m_rr = 0, m_left = 0;
  logic [15:0] m_lfsr = 16'hFFFF;
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [15:0] step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction
  function automatic int pick(input logic [N-1:0] r, input int ptr);
    int i;
    if (PRIO0 && r[0]) return 0;
    for (int k = 0; k < N; k++) begin
      i = (ptr + k) % N;
      if (r[i] && !(PRIO0 && i == 0)) return i;
    end
    return 0;
  endfunction
  // Reference model: one grant per idle sample, busy for W+1 cycles afterwards
  initial begin
    int g;
    forever begin
      @(posedge clk_in);
      cyc++;
      if (!rst_n_in) begin
        m_lfsr = 16'hFFFF;
        m_rr = 0;
        m_left = 0;
        q.delete();
      end else if (m_left > 0) m_left--;
      else if (seed_valid_in) m_lfsr = (seed_in == 16'h0) ? 16'hFFFF : seed_in;
      else if (req_in != '0) begin
        g = pick(req_in, m_rr);
        repeat (W) m_lfsr = step(m_lfsr);
        q.push_back('{id: g, word: m_lfsr[7:0], at: cyc + W});
        if (!(PRIO0 && g == 0)) m_rr = (g + 1) % N;
        m_left = W + 1;
      end
    end
  end
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (rst_n_in) begin
        chk("busy", 32'(busy_out), 32'(m_left != 0));
        if (q.size() > 0 && cyc > q[0].at) begin
          total++;
          bad++;
          $display("FAIL missing_delivery: no valid at cycle %0d for id %0d", q[0].at, q[0].id);
          void'(q.pop_front());
        end
        if (valid_out) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid: id %0h word %0h at cycle %0d, none expected", word_id_out, word_out, cyc);
          end else begin
            e = q.pop_front();
            chk("word", 32'(word_out), 32'(e.word));
            chk("word_id", 32'(word_id_out), 32'(e.id));
            chk("ack_onehot", 32'(ack_out), 32'(1) << e.id);
            chk("deliver_cycle", 32'(cyc), 32'(e.at));
          end
        end else chk("ack_idle", 32'(ack_out), 32'h0);
      end
    end
  end
  task automatic wait_acks(input int n, input int budget, output logic [7:0] first);
    int seen = 0, t = 0;
    first = '0;
    while (seen < n && t < budget) begin
      @(negedge clk_in);
      t++;
      if (ack_out != '0) begin
        if (seen == 0) first = word_out;
        seen++;
      end
    end
    total++;
    if (seen < n) begin
      bad++;
      $display("FAIL ack_timeout: got %0d acks expected %0d", seen, n);
    end
  endtask
  task automatic chk_reset_outs();
    chk("rst_ack", 32'(ack_out), 32'h0);
    chk("rst_valid", 32'(valid_out), 32'h0);
    chk("rst_word", 32'(word_out), 32'h0);
    chk("rst_id", 32'(word_id_out), 32'h0);
    chk("rst_busy", 32'(busy_out), 32'h0);
  endtask
  initial begin
    logic [7:0] fw;
    rst_n_in = 1'b0;
    req_in = '0;
    seed_valid_in = 1'b0;
    seed_in = '0;
    repeat (3) @(negedge clk_in);
    chk_reset_outs();
    rst_n_in = 1'b1;
    req_in = 4'b0001;
    wait_acks(2, 40, fw);
    chk("first_word_after_reset", 32'(fw), 32'h00);
    req_in = '0;
    rst_n_in = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    req_in = 4'b1111;
    wait_acks(5, 80, fw);
    req_in = '0;
    repeat (3) @(negedge clk_in);
    seed_valid_in = 1'b1;
    seed_in = 16'h0000;
    @(negedge clk_in);
    seed_valid_in = 1'b0;
    req_in = 4'b0010;
    wait_acks(1, 20, fw);
    chk("word_after_zero_seed", 32'(fw), 32'h00);
    req_in = '0;
    repeat (2) @(negedge clk_in);
    req_in = 4'b0100;
    repeat (3) @(negedge clk_in);
    seed_valid_in = 1'b1;
    seed_in = 16'h1234;
    @(negedge clk_in);
    seed_valid_in = 1'b0;
    wait_acks(1, 20, fw);
    req_in = '0;
    repeat (3) @(negedge clk_in);
    req_in = 4'b0100;
    @(negedge clk_in);
    req_in = '0;
    wait_acks(1, 20, fw);
    repeat (20) @(negedge clk_in);
    req_in = 4'b0001;
    repeat (4) @(negedge clk_in);
    #2 rst_n_in = 1'b0;
    #1 chk_reset_outs();
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    wait_acks(1, 20, fw);
    chk("first_word_after_abort", 32'(fw), 32'h00);
    req_in = 4'b0011;
    wait_acks(3, 60, fw);
    req_in = 4'b0010;
    wait_acks(1, 30, fw);
    req_in = '0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk_in);
      for (int i = 0; i < N; i++)
        if (ack_out[i]) req_in[i] = ($urandom_range(3) == 0);
        else if (!req_in[i]) req_in[i] = ($urandom_range(5) == 0);
      seed_valid_in = ($urandom_range(9) == 0);
      seed_in = ($urandom_range(2) == 0) ? 16'h0 : 16'($urandom);
    end
    req_in = '0;
    seed_valid_in = 1'b0;
    repeat (25) @(negedge clk_in);
    chk("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
